// File: rtl/add128_sched_if.sv
// Request/result bundle for add128_sched: two requester channels and one result channel.
// res_ovf exists only when ADD128_SCHED_OVF_EN is defined.
interface add128_sched_if #(
    parameter int unsigned N = 128
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_cin;

    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_sum;
    logic         res_cout;
    logic         res_id;
`ifdef ADD128_SCHED_OVF_EN
    logic         res_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id, res_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id, res_ovf
    );
`else
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id
    );
`endif
endinterface

// File: rtl/add128_sched.sv
// N-bit adder built from one W-bit slice time-shared over N/W beats, two round-robin requesters.
// Define ADD128_SCHED_OVF_EN to add the res_ovf signed-overflow output.
module add128_sched #(
    parameter int unsigned N = 128,
    parameter int unsigned W = 32
) (
    input logic           clk,
    input logic           rst_n,
    add128_sched_if.slave bus
);
    localparam int unsigned B     = N / W;
    localparam int unsigned BeatW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic             last_q, last_d;

    logic             grant;
    logic             accept;
    logic             last_beat;
    logic [31:0]      off;
    logic [W-1:0]     a_slice;
    logic [W-1:0]     b_slice;
    logic [W:0]       slice_sum;

    // Tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign bus.req0_ready = (state_q == StIdle) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state_q == StIdle) && bus.req1_valid && grant;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign off       = 32'(beat_q) * W;
    assign a_slice   = a_q[off +: W];
    assign b_slice   = b_q[off +: W];
    assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, carry_q};
    assign last_beat = (beat_q == BeatW'(B - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = grant ? bus.req1_a : bus.req0_a;
                    b_d     = grant ? bus.req1_b : bus.req0_b;
                    carry_d = grant ? bus.req1_cin : bus.req0_cin;
                    id_d    = grant;
                    last_d  = grant;
                    beat_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[off +: W] = slice_sum[W-1:0];
                carry_d         = slice_sum[W];
                beat_d          = beat_q + BeatW'(1);
                if (last_beat) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // After the final beat the carry register holds the carry out of the MSB.
    assign bus.res_valid = (state_q == StDone);
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = carry_q;
    assign bus.res_id    = id_q;

`ifdef ADD128_SCHED_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StRun && last_beat) begin
            ovf_d = a_slice[W-1] ^ b_slice[W-1] ^ slice_sum[W-1] ^ slice_sum[W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.res_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_add128_sched.sv
// Directed self-checking bench for add128_sched; expected values are hand-computed constants.
module tb_add128_sched;
    localparam int unsigned N = 128;
    localparam int unsigned W = 32;
    localparam int unsigned B = N / W;
    localparam logic [N-1:0] Ones = '1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    add128_sched_if #(.N(N)) bus ();

    add128_sched #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one request, confirm it is granted, then scramble the inputs after acceptance.
    task automatic issue(input bit k, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin);
        if (k) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1'b1;
        end
        #1;
        chk(k ? "issue_ready1" : "issue_ready0", k ? bus.req1_ready : bus.req0_ready, 1);
        chk("issue_other_ready", k ? bus.req0_ready : bus.req1_ready, 0);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = ~a; bus.req0_b = ~b; bus.req0_cin = ~cin;
        bus.req1_a = ~a; bus.req1_b = ~b; bus.req1_cin = ~cin;
    endtask

    task automatic expect_res(input string tag, input logic [N-1:0] sum, input logic cout,
                              input logic id);
        bit early = 1'b0;
        for (int i = 1; i < int'(B); i++) begin
            cyc();
            if (bus.res_valid !== 1'b0) early = 1'b1;
        end
        chk({tag, "_early_valid"}, early, 0);
        cyc();
        chk({tag, "_valid"}, bus.res_valid, 1);
        chk({tag, "_sum"}, bus.res_sum, sum);
        chk({tag, "_cout"}, bus.res_cout, cout);
        chk({tag, "_id"}, bus.res_id, id);
    endtask

    task automatic drain(input string tag);
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        chk({tag, "_drained"}, bus.res_valid, 0);
    endtask

    int   acc_t [8];
    logic acc_id [8];
    int   n_acc;
    int   n_res;
    bit   both_rdy;
    bit   bad;
    logic [N-1:0] hold_sum;

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.res_ready = 1'b0;
        #2;
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_sum", bus.res_sum, 0);
        chk("rst_cout", bus.res_cout, 0);
        chk("rst_id", bus.res_id, 0);
`ifdef ADD128_SCHED_OVF_EN
        chk("rst_ovf", bus.res_ovf, 0);
`endif
        rst_n = 1'b1;

        // Simple add, accepted on the first edge after release.
        issue(1'b0, 128'h1, 128'h2, 1'b0);
        expect_res("add_1_2", 128'h3, 1'b0, 1'b0);
        drain("add_1_2");

        // Carry ripples through every beat; res_ready already high before the result.
        bus.res_ready = 1'b1;
        issue(1'b1, Ones, 128'h0, 1'b1);
        expect_res("ripple", 128'h0, 1'b1, 1'b1);
        cyc();
        chk("early_ready_drain", bus.res_valid, 0);
        bus.res_ready = 1'b0;

        issue(1'b0, Ones, Ones, 1'b1);
        expect_res("ones_ones", Ones, 1'b1, 1'b0);
        drain("ones_ones");

        // Both requesters valid from reset with a ready consumer: alternate grants.
        rst_n = 1'b0;
        bus.req0_a = 128'd5;  bus.req0_b = 128'd6;  bus.req0_cin = 1'b0; bus.req0_valid = 1'b1;
        bus.req1_a = 128'd10; bus.req1_b = 128'd20; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        bus.res_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        n_acc = 0; n_res = 0; both_rdy = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) both_rdy = 1'b1;
            if ((bus.req0_ready || bus.req1_ready) && n_acc < 8) begin
                acc_t[n_acc]  = c;
                acc_id[n_acc] = bus.req1_ready;
                n_acc++;
            end
            if (bus.res_valid) begin
                chk("rr_res_id", bus.res_id, n_res % 2);
                chk("rr_res_sum", bus.res_sum, (n_res % 2) ? 30 : 11);
                n_res++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cyc();
        bus.res_ready = 1'b0;
        chk("rr_accepts", n_acc, 4);
        chk("rr_results", n_res, 4);
        chk("rr_both_ready", both_rdy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant_id", acc_id[i], i % 2);
            chk("rr_accept_time", acc_t[i], 6 * i);
        end

        // Result held for 10 cycles while both requesters wait.
        hold_sum = 128'h0000_0001_ffff_ffff_0000_0001_0000_0001;
        issue(1'b0, 128'h0000_0001_ffff_ffff_0000_0000_ffff_ffff, 128'h1, 1'b1);
        expect_res("hold", hold_sum, 1'b0, 1'b0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.res_valid !== 1'b1 || bus.res_sum !== hold_sum || bus.res_cout !== 1'b0 ||
                bus.res_id !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
                bad = 1'b1;
            cyc();
        end
        chk("hold_stable", bad, 0);
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        chk("hold_released", bus.res_valid, 0);
        chk("hold_next_grant1", bus.req1_ready, 1);
        chk("hold_next_grant0", bus.req0_ready, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset in the middle of an operation discards it.
        issue(1'b1, 128'd5, 128'd7, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.res_valid, 0);
        chk("abort_sum", bus.res_sum, 0);
        chk("abort_cout", bus.res_cout, 0);
        chk("abort_id", bus.res_id, 0);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.res_valid !== 1'b0) bad = 1'b1;
        end
        chk("abort_no_result", bad, 0);
        issue(1'b0, 128'h0000_0000_0000_0000_ffff_ffff_ffff_ffff, 128'h1, 1'b0);
        expect_res("after_abort", 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0);
        drain("after_abort");

`ifdef ADD128_SCHED_OVF_EN
        issue(1'b0, {1'b0, {(N-1){1'b1}}}, 128'h1, 1'b0);
        expect_res("ovf_pos", {1'b1, {(N-1){1'b0}}}, 1'b0, 1'b0);
        chk("ovf_pos_flag", bus.res_ovf, 1);
        drain("ovf_pos");
        issue(1'b1, Ones, 128'h1, 1'b0);
        expect_res("ovf_none", 128'h0, 1'b1, 1'b1);
        chk("ovf_none_flag", bus.res_ovf, 0);
        drain("ovf_none");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
